// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: buffers per-pixel results in a FIFO and serialises them as
// a byte stream (optional frame sync byte, gray, blurred, flag byte) over a
// valid/ready handshake, tagging line and frame boundaries.
module pixel_stream_tx #(
  parameter int          IMG_W      = 64,
  parameter int          IMG_H      = 48,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] gray,
  input  logic [7:0] blurred,
  input  logic       binary,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic       frame_done,
  output logic       overflow
);

  localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, SYNC, B0, B1, B2} state_t;

  state_t        state;
  logic          sof;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          line_end, frame_end;

  logic [18:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, empty, push, pop, hs, sof_next;
  logic [18:0]   head, hold;

  // Position of the next accepted pixel decides its geometry flags.
  assign line_end  = (x == XW'(IMG_W - 1));
  assign frame_end = line_end & (y == YW'(IMG_H - 1));

  // Full is taken from the registered count, so a same-cycle pop never frees a slot early.
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~rst & ~full;
  assign push     = in_valid & in_ready;
  assign hs       = tx_valid & tx_ready;
  assign pop      = ~empty & ((state == IDLE) | ((state == B2) & hs));
  assign head     = mem[rd_ptr];
  // A frame-end pixel leaving on this handshake re-arms the sync byte for the next pixel.
  assign sof_next = sof | hold[0];

  // FIFO storage; data only, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {gray, blurred, binary, line_end, frame_end};
  end

  // Pixel being serialised; loaded whenever the FSM pops the FIFO head.
  always_ff @(posedge clk) begin
    if (pop) hold <= head;
  end

  // FIFO pointers, occupancy, pixel position counters and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      x        <= '0;
      y        <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (line_end) begin
          x <= '0;
          y <= frame_end ? '0 : y + 1'b1;
        end else begin
          x <= x + 1'b1;
        end
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
      if (in_valid & ~in_ready) overflow <= 1'b1;
    end
  end

  // Byte serialiser FSM with registered tx outputs; pops the next pixel on the
  // last byte's handshake so back-to-back pixels have no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sof        <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            tx_valid <= 1'b1;
            if (sof) begin
              state   <= SYNC;
              tx_data <= SYNC_BYTE;
              sof     <= 1'b0;
            end else begin
              state   <= B0;
              tx_data <= head[18:11];
            end
          end
        end
        SYNC: if (hs) begin
          state   <= B0;
          tx_data <= hold[18:11];
        end
        B0: if (hs) begin
          state   <= B1;
          tx_data <= hold[10:3];
        end
        B1: if (hs) begin
          state   <= B2;
          tx_data <= {hold[2:0], 5'b0};
        end
        B2: if (hs) begin
          frame_done <= hold[0];
          if (!empty) begin
            if (sof_next) begin
              state   <= SYNC;
              tx_data <= SYNC_BYTE;
              sof     <= 1'b0;
            end else begin
              state   <= B0;
              tx_data <= head[18:11];
            end
          end else begin
            state    <= IDLE;
            tx_valid <= 1'b0;
            sof      <= sof_next;
          end
        end
        default: begin
          state    <= IDLE;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Scoreboard bench for pixel_stream_tx: the driver feeds a frame-geometry
// reference model on every accepted pixel; a monitor checks each transferred byte.
module tb_pixel_stream_tx;

  localparam int W = 4;
  localparam int H = 2;
  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] gray = 8'h00;
  logic [7:0] blurred = 8'h00;
  logic       binary = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       frame_done;
  logic       overflow;

  pixel_stream_tx #(.IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .gray(gray), .blurred(blurred), .binary(binary),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .frame_done(frame_done), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    bit         fe;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   px_n    = 0;
  int   fd_seen = 0;

  bit         fd_pend = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data = 8'h00;
  exp_t       mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Reference model: the frame position comes from the count of accepted
  // pixels since reset; a sync byte precedes pixel (0,0) of every frame.
  function automatic void model_accept(input logic [7:0] g, input logic [7:0] bl, input logic bi);
    int x, y;
    bit le, fe;
    exp_t e;
    x  = px_n % W;
    y  = (px_n / W) % H;
    le = (x == W - 1);
    fe = le && (y == H - 1);
    if (x == 0 && y == 0) begin
      e.b = 8'hA5; e.fe = 0; exp_q.push_back(e);
    end
    e.b = g;  e.fe = 0; exp_q.push_back(e);
    e.b = bl; e.fe = 0; exp_q.push_back(e);
    e.b = {bi, le, fe, 5'b0}; e.fe = fe; exp_q.push_back(e);
    px_n++;
  endfunction

  // One clock of stimulus; in_ready is stable between edges, so an accept
  // seen here is exactly what the DUT will take on the next rising edge.
  task automatic cyc(input logic v, input logic [7:0] g, input logic [7:0] bl,
                     input logic bi, input logic tr, output bit acc);
    @(negedge clk);
    in_valid = v; gray = g; blurred = bl; binary = bi; tx_ready = tr;
    acc = v && in_ready && !rst;
    if (acc) model_accept(g, bl, bi);
  endtask

  task automatic do_reset(input int cyc_n, input logic tr);
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; tx_ready = tr; px_n = 0;
    repeat (cyc_n - 1) @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    bit acc, done;
    done = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, acc);
      if (exp_q.size() == 0 && !tx_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
    end
  endtask

  // Monitor: compares every transferred byte with the scoreboard head,
  // checks frame_done one cycle after a frame-end byte, and checks that a
  // stalled byte stays put.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      exp_q.delete();
      fd_pend    = 0;
      prev_stall = 0;
    end else begin
      if (fd_pend || frame_done) begin
        chk("frame_done", {31'b0, frame_done}, {31'b0, fd_pend});
        if (frame_done) fd_seen++;
      end
      fd_pend = 0;
      if (prev_stall) chk("stall_hold", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_byte: got %0h, expected none", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_byte", {24'b0, tx_data}, {24'b0, mon_e.b});
          fd_pend = mon_e.fe;
        end
      end
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, found;
    int n_acc;

    // Reset state
    do_reset(2, 1'b0);
    #1;
    chk("rst_tx_valid", {31'b0, tx_valid}, 0);
    chk("rst_tx_data", {24'b0, tx_data}, 0);
    chk("rst_in_ready", {31'b0, in_ready}, 1);
    chk("rst_overflow", {31'b0, overflow}, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);

    // One full frame plus the first pixel of the next
    fd_seen = 0;
    for (int i = 0; i < 9; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      cyc(1'b1, iv, 8'h80 + iv, iv[0], 1'b1, acc);
      chk("frame_accept", {31'b0, acc}, 1);
    end
    drain();
    chk("frame_done_count", fd_seen, 1);

    // Backpressure while the blurred byte 81 is presented
    do_reset(1, 1'b1);
    cyc(1'b1, 8'h00, 8'h80, 1'b0, 1'b1, acc);
    cyc(1'b1, 8'h01, 8'h81, 1'b1, 1'b1, acc);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (tx_valid && tx_data == 8'h81) begin
        tx_ready = 1'b0;
        found = 1;
        break;
      end
    end
    chk("stall_found", {31'b0, found}, 1);
    if (found) begin
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        chk("stall_data", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h81});
      end
      tx_ready = 1'b1;
    end
    drain();

    // Fill with the output blocked: FIFO plus hold register, then drop
    do_reset(1, 1'b0);
    n_acc = 0;
    for (int i = 0; i < 18; i++) begin
      cyc(1'b1, 8'(8'h10 + i), 8'(8'h40 + i), 1'b0, 1'b0, acc);
      if (i == 17) chk("full_in_ready", {31'b0, in_ready}, 0);
      if (acc) n_acc++;
    end
    chk("accepted_count", n_acc, 17);
    cyc(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, acc);
    chk("overflow_set", {31'b0, overflow}, 1);
    drain();
    chk("overflow_sticky", {31'b0, overflow}, 1);
    do_reset(1, 1'b1);
    #1;
    chk("overflow_cleared", {31'b0, overflow}, 0);

    // Reset mid-pixel, mid-frame
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(i), 8'(8'h80 + i), 1'b0, 1'b1, acc);
    found = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (tx_valid && tx_data == 8'h81) begin
        found = 1;
        break;
      end
    end
    chk("midb1_found", {31'b0, found}, 1);
    rst = 1'b1; px_n = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_tx_valid", {31'b0, tx_valid}, 0);
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h20 + i), 8'(8'h60 + i), i[0], 1'b1, acc);
    drain();

    // Random traffic over several frames
    do_reset(1, 1'b1);
    for (int i = 0; i < 4000 && px_n < 3 * W * H + 5; i++) begin
      cyc(($urandom_range(0, 2) == 0), 8'($urandom), 8'($urandom), 1'($urandom),
          ($urandom_range(0, 3) != 0), acc);
    end
    chk("random_progress", {31'b0, (px_n >= 3 * W * H)}, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
